// File: rtl/spi_sram_responder.sv
// SPI master that turns single-word memory requests into 48-bit SPI SRAM
// frames (command, 24-bit byte address, 16-bit data) using SPI mode 0.
// Handshake: a request is taken on a rising clk edge where req=1 and
// off_chip_mem_ready=1. Ready stays low until the frame finishes. A read
// returns its word on rd_data together with a one-cycle rd_valid pulse.
module spi_sram_responder #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        memory_we,
  input  logic [15:0] address,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        off_chip_mem_ready,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic        rd_valid_q, rd_valid_d;
  logic [47:0] shift_q, shift_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [5:0]  bit_q, bit_d;
  logic [7:0]  div_q, div_d;

  logic active, tick, rise, fall, accept;

  // Frame timing events: a tick ends one SCLK half-period.
  always_comb begin
    active = 1'b0;
    if (state_q == CMD || state_q == ADDR || state_q == DATA) active = !cs_n_q;
    tick   = active && (div_q == DIV_LAST);
    rise   = tick && !sclk_q;
    fall   = tick && sclk_q;
    accept = (state_q == IDLE) && req && ready_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: phases advance on the falling SCLK edge ending the phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = CMD;
      CMD:  if (fall && bit_q == 6'd7)  state_d = ADDR;
      ADDR: if (fall && bit_q == 6'd31) state_d = DATA;
      DATA: if (fall && bit_q == 6'd47) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: shift out on SCLK fall, sample on SCLK rise.
  always_comb begin
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ready_d    = ready_q;
    we_d       = we_q;
    rd_valid_d = 1'b0;
    shift_d    = shift_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    bit_d      = bit_q;
    div_d      = div_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          we_d    = memory_we;
          shift_d = {(memory_we ? 8'h02 : 8'h03), 7'b0, address, 1'b0,
                     (memory_we ? wr_data : 16'h0000)};
          bit_d   = 6'd0;
          div_d   = 8'd0;
        end
      end
      CMD, ADDR, DATA: begin
        if (cs_n_q) begin
          // First cycle after accept: select the device, present bit 47.
          cs_n_d = 1'b0;
          sclk_d = 1'b0;
          mosi_d = shift_q[47];
          div_d  = 8'd0;
        end else if (tick) begin
          div_d  = 8'd0;
          sclk_d = !sclk_q;
          if (rise) begin
            if (state_q == DATA) rx_d = {rx_q[14:0], miso};
          end else begin
            bit_d   = bit_q + 6'd1;
            shift_d = {shift_q[46:0], 1'b0};
            mosi_d  = (bit_q == 6'd47) ? 1'b0 : shift_q[46];
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE: begin
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        ready_d = 1'b1;
        bit_d   = 6'd0;
        div_d   = 8'd0;
        if (!we_q) begin
          rd_data_d  = rx_q;
          rd_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      shift_q    <= 48'h0;
      rx_q       <= 16'h0;
      rd_data_q  <= 16'h0;
      bit_q      <= 6'd0;
      div_q      <= 8'd0;
    end else begin
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      rd_valid_q <= rd_valid_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
    end
  end

  assign cs_n               = cs_n_q;
  assign sclk               = sclk_q;
  assign mosi               = mosi_q;
  assign off_chip_mem_ready = ready_q;
  assign rd_valid           = rd_valid_q;
  assign rd_data            = rd_data_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: instance 0 uses CLK_DIV=2, instance 1 uses
// CLK_DIV=1. Each instance talks to a behavioural SPI SRAM; frames and read
// words are predicted from a word-addressed reference memory.
module tb_spi_sram_responder;

  logic        clk;
  logic        rst_n;
  logic        req_v[2];
  logic        memory_we_v[2];
  logic [15:0] address_v[2];
  logic [15:0] wr_data_v[2];
  logic [15:0] rd_data_v[2];
  logic        rd_valid_v[2];
  logic        ready_v[2];
  logic        sclk_v[2];
  logic        cs_n_v[2];
  logic        mosi_v[2];
  logic        miso_v[2];

  int checks = 0;
  int errors = 0;
  bit abort_flag = 0;
  logic [15:0] last_rd[2];

  // Scoreboard queues, tagged with the instance number in the top bit.
  logic [48:0] exp_frame_q[$];
  logic [16:0] exp_rd_q[$];

  // Device memory (seen by the SPI slaves) and reference memory (model).
  logic [15:0] dev_mem[logic [15:0]];
  logic [15:0] ref_mem[logic [15:0]];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_sram_responder #(.CLK_DIV(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .memory_we(memory_we_v[0]),
    .address(address_v[0]), .wr_data(wr_data_v[0]), .rd_data(rd_data_v[0]),
    .rd_valid(rd_valid_v[0]), .off_chip_mem_ready(ready_v[0]), .sclk(sclk_v[0]),
    .cs_n(cs_n_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0]));

  spi_sram_responder #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .memory_we(memory_we_v[1]),
    .address(address_v[1]), .wr_data(wr_data_v[1]), .rd_data(rd_data_v[1]),
    .rd_valid(rd_valid_v[1]), .off_chip_mem_ready(ready_v[1]), .sclk(sclk_v[1]),
    .cs_n(cs_n_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1]));

  function automatic int div_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  function automatic logic [15:0] default_word(input logic [15:0] a);
    return a ^ 16'h5AA5;
  endfunction

  function automatic logic [15:0] dev_rd(input logic [15:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return default_word(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return default_word(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SPI SRAM slaves + frame monitor ----------------
  for (genvar g = 0; g < 2; g++) begin : g_slv
    logic [47:0] cap;
    logic [15:0] rword;
    int          cnt;

    always @(negedge cs_n_v[g]) begin
      cnt = 0;
      cap = '0;
      miso_v[g] = 1'b0;
    end

    // Mode 0: capture mosi on SCLK rise, then present the next miso bit.
    always @(posedge sclk_v[g]) begin
      if (!cs_n_v[g]) begin
        cap = {cap[46:0], mosi_v[g]};
        cnt++;
        if (cnt == 32) rword = dev_rd(cap[16:1]);
        if (cnt >= 32 && cnt < 48) miso_v[g] = rword[47 - cnt];
      end
    end

    // End of frame: compare against the expected queue, apply writes.
    always @(posedge cs_n_v[g]) begin
      if (!abort_flag) begin
        logic [48:0] e;
        if (exp_frame_q.size() == 0) begin
          chk("unexpected_frame", {15'h0, cap}, 64'h0);
        end else begin
          e = exp_frame_q.pop_front();
          chk("frame_bits", {15'(g), cap}, {15'h0, e});
          chk("frame_rises", 64'(cnt), 64'd48);
          if (cnt == 48 && cap[47:40] == 8'h02) dev_mem[cap[32:17]] = cap[15:0];
        end
      end
    end
  end

  // ---------------- read-data monitor ----------------
  logic prev_rv[2];
  initial begin
    prev_rv[0] = 1'b0;
    prev_rv[1] = 1'b0;
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst_n === 1'b1 && rd_valid_v[g] === 1'b1) begin
        chk("rd_valid_single", 64'(prev_rv[g]), 64'd0);
        if (exp_rd_q.size() == 0) begin
          chk("unexpected_rd_valid", 64'(rd_data_v[g]), 64'h0);
        end else begin
          logic [16:0] e;
          e = exp_rd_q.pop_front();
          chk("rd_data", {47'h0, 1'(g), rd_data_v[g]}, {47'h0, e});
        end
      end
      if (rst_n === 1'b1 && cs_n_v[g] === 1'b1)
        chk("idle_lines", {62'h0, sclk_v[g], mosi_v[g]}, 64'h0);
      prev_rv[g] = rd_valid_v[g];
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [47:0] make_frame(input bit we, input logic [15:0] a,
                                             input logic [15:0] d);
    logic [23:0] ba;
    ba = 24'(a) * 24'd2;
    return {(we ? 8'h02 : 8'h03), ba, (we ? d : 16'h0000)};
  endfunction

  // Called at the negedge right after the accept edge; returns at the
  // negedge where ready is seen high again.
  task automatic wait_frame(input int g, input logic [47:0] fr, input bit we,
                            input logic [15:0] exp_rd);
    int d;
    int n;
    d = div_of(g);
    chk("ready_low_after_accept", 64'(ready_v[g]), 64'd0);
    chk("cs_high_at_accept", 64'(cs_n_v[g]), 64'd1);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (ready_v[g] === 1'b1) break;
      if (n > 96 * d + 10) begin
        chk("frame_timeout", 64'(n), 64'(96 * d + 2));
        break;
      end
      if (n <= 96 * d) begin
        int k;
        k = (n - 1) / (2 * d);
        chk("wave", {61'h0, cs_n_v[g], sclk_v[g], mosi_v[g]},
            {61'h0, 1'b0, 1'(((n - 1) / d) % 2), fr[47 - k]});
      end else begin
        chk("done_state", {61'h0, cs_n_v[g], sclk_v[g], mosi_v[g]}, 64'h0);
      end
    end
    chk("latency", 64'(n), 64'(2 + 96 * d));
    chk("cs_high_end", 64'(cs_n_v[g]), 64'd1);
    chk("rd_valid_at_end", 64'(rd_valid_v[g]), 64'(!we));
    if (we) chk("rd_data_kept", 64'(rd_data_v[g]), 64'(last_rd[g]));
    else    last_rd[g] = exp_rd;
  endtask

  // Issue one request on instance g; expectations are queued before it starts.
  task automatic issue(input int g, input bit we, input logic [15:0] a,
                       input logic [15:0] d, output logic [47:0] fr,
                       output logic [15:0] er);
    req_v[g]       = 1'b1;
    memory_we_v[g] = we;
    address_v[g]   = a;
    wr_data_v[g]   = d;
    fr = make_frame(we, a, d);
    er = ref_rd(a);
    exp_frame_q.push_back({1'(g), fr});
    if (we) ref_mem[a] = d;
    else    exp_rd_q.push_back({1'(g), er});
  endtask

  task automatic do_txn(input int g, input bit we, input logic [15:0] a,
                        input logic [15:0] d, input int gap);
    logic [47:0] fr;
    logic [15:0] er;
    repeat (gap) @(negedge clk);
    issue(g, we, a, d, fr, er);
    @(posedge clk);
    @(negedge clk);
    req_v[g] = 1'b0;
    wait_frame(g, fr, we, er);
  endtask

  // req held high across a frame: exactly one extra frame follows.
  task automatic back_to_back(input int g, input bit we, input logic [15:0] a,
                              input logic [15:0] d);
    logic [47:0] fr;
    logic [15:0] er;
    issue(g, we, a, d, fr, er);
    @(posedge clk);
    @(negedge clk);
    wait_frame(g, fr, we, er);
    issue(g, we, a, d, fr, er);
    @(posedge clk);
    @(negedge clk);
    req_v[g] = 1'b0;
    wait_frame(g, fr, we, er);
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] pool[8];

  initial begin
    for (int g = 0; g < 2; g++) begin
      req_v[g] = 1'b0;
      memory_we_v[g] = 1'b0;
      address_v[g] = 16'h0;
      wr_data_v[g] = 16'h0;
      miso_v[g] = 1'b0;
      last_rd[g] = 16'h0;
    end
    dev_mem[16'hFFFF] = 16'hA5C3;
    ref_mem[16'hFFFF] = 16'hA5C3;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset_cs_n", 64'(cs_n_v[g]), 64'd1);
      chk("reset_sclk_mosi", {62'h0, sclk_v[g], mosi_v[g]}, 64'h0);
      chk("reset_ready", 64'(ready_v[g]), 64'd1);
      chk("reset_rd", {47'h0, rd_valid_v[g], rd_data_v[g]}, 64'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: write then read at the upper address boundary.
    do_txn(0, 1'b1, 16'h1234, 16'hBEEF, 0);
    do_txn(0, 1'b0, 16'hFFFF, 16'h0000, 0);
    do_txn(0, 1'b0, 16'h1234, 16'h0000, 1);

    // req held high for a whole frame.
    back_to_back(0, 1'b0, 16'h4321, 16'h0000);

    // Reset in the middle of the address phase.
    issue_abort();

    do_txn(0, 1'b0, 16'h0001, 16'h0000, 0);

    // CLK_DIV=1 instance: read, write, read back.
    do_txn(1, 1'b0, 16'hFFFF, 16'h0000, 0);
    do_txn(1, 1'b1, 16'h00A0, 16'h1357, 0);
    do_txn(1, 1'b0, 16'h00A0, 16'h0000, 2);

    // Randomised traffic over a small address pool to hit read-after-write.
    pool[0] = 16'h0000; pool[1] = 16'hFFFF; pool[2] = 16'h1234; pool[3] = 16'h8000;
    for (int i = 4; i < 8; i++) pool[i] = 16'($urandom);
    for (int i = 0; i < 14; i++) begin
      int g;
      g = (i % 3 == 2) ? 1 : 0;
      do_txn(g, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
             16'($urandom), $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    chk("frames_left", 64'(exp_frame_q.size()), 64'd0);
    chk("reads_left", 64'(exp_rd_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic issue_abort();
    int guard;
    req_v[0] = 1'b1;
    memory_we_v[0] = 1'b0;
    address_v[0] = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    req_v[0] = 1'b0;
    guard = 0;
    while (!(g_slv[0].cnt >= 12 && g_slv[0].cnt <= 28 && cs_n_v[0] === 1'b0)) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        chk("abort_wait_timeout", 64'(guard), 64'd0);
        break;
      end
    end
    abort_flag = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 64'(cs_n_v[0]), 64'd1);
    chk("abort_sclk_mosi", {62'h0, sclk_v[0], mosi_v[0]}, 64'h0);
    chk("abort_ready", 64'(ready_v[0]), 64'd1);
    chk("abort_rd", {47'h0, rd_valid_v[0], rd_data_v[0]}, 64'h0);
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    abort_flag = 1'b0;
  endtask

endmodule
